// File: rtl/neuraedge_perf_csr_slave_if.sv
// Single-beat CSR port between the tile CSR master and the performance-counter slave.
// Handshake: master raises csr_valid with csr_write/csr_addr/csr_wdata; an idle slave accepts on
// that edge and answers with a one-cycle csr_ready carrying csr_rdata/csr_err. Nothing is queued.
interface neuraedge_perf_csr_slave_if;
    logic        csr_valid;
    logic        csr_write;
    logic [7:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_ready;
    logic        csr_err;

    modport master (
        output csr_valid, csr_write, csr_addr, csr_wdata,
        input  csr_rdata, csr_ready, csr_err
    );

    modport slave (
        input  csr_valid, csr_write, csr_addr, csr_wdata,
        output csr_rdata, csr_ready, csr_err
    );
endinterface

// File: rtl/neuraedge_perf_csr_slave.sv
// Tile performance counters with sticky overflow flags, a CTRL register and an overflow IRQ,
// served over a single-beat CSR port (IDLE -> RESP responder).
module neuraedge_perf_csr_slave #(
    parameter int           NUM_CNT  = 6,
    parameter int           CNT_W    = 32,
    parameter int           INC_W    = 16,
    parameter logic [7:0]   CSR_BASE = 8'h80,
    parameter int           SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    neuraedge_perf_csr_slave_if.slave   csr,
    input  logic [NUM_CNT-1:0]          inc_valid,
    input  logic [NUM_CNT*INC_W-1:0]    inc_amt,
    output logic [NUM_CNT*CNT_W-1:0]    counters_flat,
    output logic [7:0]                  overflow_flags,
    output logic                        overflow_irq,
    output logic                        dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam logic [5:0] BASE_WORD = CSR_BASE[7:2];
    localparam logic [5:0] CTRL_WORD = 6'h26;
    localparam logic [5:0] OVF_WORD  = 6'h27;

    state_e               state_q, state_d;
    logic                 accept;

    logic [CNT_W-1:0]     cnt_q [NUM_CNT];
    logic [CNT_W-1:0]     cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0]   flag_q, flag_d;
    logic [NUM_CNT-1:0]   ovf_set;
    logic                 en_q, en_d;
    logic [7:0]           mask_q, mask_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 irq_q, irq_d;

    logic [5:0]           word;
    logic [5:0]           cnt_off;
    logic                 hit_ctrl, hit_ovf, hit_cnt;
    logic                 wr, clear_all, w1c;
    logic [CNT_W-1:0]     wdata_cnt;
    logic [CNT_W:0]       sum;
    logic [31:0]          rd_val;
    logic                 unused_addr_lsb;

    // FSM state register and next-state logic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (csr.csr_valid) begin
                    accept  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address decode on word address; CTRL/OVF win if the counter window ever overlaps them.
    assign word            = csr.csr_addr[7:2];
    assign unused_addr_lsb = ^csr.csr_addr[1:0];
    assign cnt_off         = word - BASE_WORD;
    assign hit_ctrl        = (word == CTRL_WORD);
    assign hit_ovf         = (word == OVF_WORD);
    assign hit_cnt         = !hit_ctrl && !hit_ovf && (word >= BASE_WORD) && (cnt_off < 6'(NUM_CNT));

    assign wr              = accept && csr.csr_write;
    assign clear_all       = wr && hit_ctrl && csr.csr_wdata[1];
    assign w1c             = wr && hit_ovf;
    assign wdata_cnt       = CNT_W'(csr.csr_wdata);

    always_comb begin
        sum     = '0;
        ovf_set = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            sum      = {1'b0, cnt_q[i]} + {{(CNT_W+1-INC_W){1'b0}}, inc_amt[i*INC_W +: INC_W]};
            if (en_q && inc_valid[i]) begin
                ovf_set[i] = sum[CNT_W];
                cnt_d[i]   = ((SATURATE != 0) && sum[CNT_W]) ? '1 : sum[CNT_W-1:0];
            end
            // A CSR write to the counter drops the same-cycle increment entirely.
            if (wr && hit_cnt && (cnt_off == 6'(i))) begin
                cnt_d[i]   = wdata_cnt;
                ovf_set[i] = 1'b0;
            end
            if (clear_all) cnt_d[i] = '0;
        end
    end

    always_comb begin
        flag_d = flag_q;
        if (w1c) flag_d = flag_d & ~csr.csr_wdata[NUM_CNT-1:0];
        flag_d = flag_d | ovf_set;
        if (clear_all) flag_d = '0;
    end

    always_comb begin
        en_d   = en_q;
        mask_d = mask_q;
        if (wr && hit_ctrl) begin
            en_d   = csr.csr_wdata[0];
            mask_d = csr.csr_wdata[15:8];
        end
    end

    always_comb begin
        rd_val = 32'h0;
        if (hit_ctrl) begin
            rd_val = {16'h0, mask_q, 6'h0, 1'b0, en_q};
        end else if (hit_ovf) begin
            rd_val = {24'h0, 8'(flag_q)};
        end else if (hit_cnt) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (cnt_off == 6'(i)) rd_val = 32'(cnt_q[i]);
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            rdata_d = csr.csr_write ? 32'h0 : rd_val;
            err_d   = !(hit_ctrl || hit_ovf || hit_cnt);
        end
    end

    // IRQ is registered from next-state values so it always agrees with overflow_flags.
    assign irq_d = |(8'(flag_d) & mask_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
            flag_q  <= '0;
            en_q    <= 1'b1;
            mask_q  <= 8'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            en_q    <= en_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        counters_flat = '0;
        for (int i = 0; i < NUM_CNT; i++) counters_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign overflow_flags = 8'(flag_q);
    assign overflow_irq   = irq_q;
    assign csr.csr_ready  = (state_q == RESP);
    assign csr.csr_rdata  = rdata_q;
    assign csr.csr_err    = err_q;
    assign dbg_state      = (state_q == RESP);

endmodule
